// File: rtl/multicycle_control_if.sv
// Memory request handshake between the multi-cycle controller and the shared
// single-port memory.
//   mem_req   : controller -> memory, access request (held until mem_ready)
//   mem_we    : controller -> memory, write enable, qualified by mem_req
//   mem_ready : memory -> controller, transfer completes when req && ready
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM for the RV32I core: FETCH, DECODE, EXECUTE, MEM,
// WRITEBACK, plus a terminal TRAP for unsupported opcodes. Owns the memory
// handshake, all architectural write strobes and the datapath operand selects.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   opcode          : IR[6:0], stable from DECODE until the next ir_write
//   branch_taken    : ALU compare result, used only in EXECUTE of a BRANCH
//   mem             : memory handshake (mem_req, mem_we, mem_ready)
//   ir_write        : load IR from memory read data
//   pc_write/pc_src : PC update strobe and next-PC source
//   alu_a_sel/b_sel : ALU operand selects
//   wb_sel          : register write-data source
//   reg_write       : register-file write strobe
//   instret         : one-cycle retire pulse, coincident with pc_write
//   illegal         : high while parked in TRAP
//   state           : current FSM state encoding
// Only the state is registered; every other output is decoded from the state
// and the current inputs, and is forced to 0 while rst is high.
module multicycle_control (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic                  branch_taken,
  multicycle_control_if.master  mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic [1:0]            alu_a_sel,
  output logic                  alu_b_sel,
  output logic [1:0]            wb_sel,
  output logic                  reg_write,
  output logic                  instret,
  output logic                  illegal,
  output logic [2:0]            state
);

  localparam int unsigned STATE_W = 3;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Select encodings
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;
  localparam logic [1:0] A_RS1    = 2'd0;
  localparam logic [1:0] A_PC     = 2'd1;
  localparam logic [1:0] A_ZERO   = 2'd2;
  localparam logic       B_RS2    = 1'b0;
  localparam logic       B_IMM    = 1'b1;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   mem_req_c;
  logic   mem_we_c;
  logic   legal_c;
  logic   is_ldst_c;

  assign legal_c = (opcode inside {OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE,
                                   OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL,
                                   OPC_OP});
  assign is_ldst_c = (opcode == OPC_LOAD) || (opcode == OPC_STORE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d   = state_q;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    wb_sel    = WB_ALU;
    reg_write = 1'b0;
    instret   = 1'b0;
    illegal   = 1'b0;

    // Reset gates every output so an in-flight request drops immediately.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req_c = 1'b1;
          if (mem.mem_ready) begin
            ir_write = 1'b1;
            state_d  = S_DECODE;
          end
        end

        S_DECODE: begin
          state_d = legal_c ? S_EXECUTE : S_TRAP;
        end

        S_EXECUTE: begin
          case (opcode)
            OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_JALR: begin
              alu_a_sel = A_RS1;
              alu_b_sel = B_IMM;
            end
            OPC_AUIPC: begin
              alu_a_sel = A_PC;
              alu_b_sel = B_IMM;
            end
            OPC_LUI: begin
              alu_a_sel = A_ZERO;
              alu_b_sel = B_IMM;
            end
            default: begin
              alu_a_sel = A_RS1;
              alu_b_sel = B_RS2;
            end
          endcase

          if (opcode == OPC_BRANCH) begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
            instret  = 1'b1;
            state_d  = S_FETCH;
          end else if (is_ldst_c) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WRITEBACK;
          end
        end

        S_MEM: begin
          mem_req_c = 1'b1;
          mem_we_c  = (opcode == OPC_STORE);
          if (mem.mem_ready) begin
            if (opcode == OPC_STORE) begin
              pc_write = 1'b1;
              instret  = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d = S_WRITEBACK;
            end
          end
        end

        S_WRITEBACK: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          instret   = 1'b1;
          state_d   = S_FETCH;
          if (opcode == OPC_LOAD) begin
            wb_sel = WB_MEM;
          end else if ((opcode == OPC_JAL) || (opcode == OPC_JALR)) begin
            wb_sel = WB_PC4;
          end
          // JALR target comes from the ALU result register latched in EXECUTE.
          if (opcode == OPC_JAL) begin
            pc_src = PC_IMM;
          end else if (opcode == OPC_JALR) begin
            pc_src = PC_ALU;
          end
        end

        S_TRAP: begin
          illegal = 1'b1;
          state_d = S_TRAP;
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of directed instructions,
// randomized instruction stream against a phase-list reference model, and
// hand-written reset / trap sequences.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       ir_write, pc_write, alu_b_sel, reg_write, instret, illegal;
  logic [1:0] pc_src, alu_a_sel, wb_sel;
  logic [2:0] state;

  multicycle_control_if mif();

  multicycle_control dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem          (mif),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .wb_sel       (wb_sel),
    .reg_write    (reg_write),
    .instret      (instret),
    .illegal      (illegal),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] ILL    = 7'b1111111;

  // Phases an instruction passes through, as seen on the state output
  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4, PH_T = 5;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic [1:0] asel;
    logic       bsel;
    logic [1:0] wbs;
    logic       rw;
    logic       ret;
    logic       ill;
  } obs_t;

  typedef struct {
    logic [6:0]  opc;
    int          mw;
    logic        bt;
    int          cyc;
    logic [1:0]  pcs;
    logic [1:0]  wbs;
    logic        rw;
    logic        we;
    logic [23:0] seq;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] opc);
    return opc inside {LOAD, OPIMM, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP};
  endfunction

  // Expected outputs for one cycle of a given phase, straight from the rules
  function automatic obs_t model(input int ph, input logic [6:0] opc,
                                 input logic bt, input logic rdy);
    obs_t o;
    o = '0;
    case (ph)
      PH_F: begin
        o.st  = 3'd0;
        o.req = 1'b1;
        o.irw = rdy;
      end
      PH_D: o.st = 3'd1;
      PH_E: begin
        o.st = 3'd2;
        if (opc == LUI)        o.asel = 2'd2;
        else if (opc == AUIPC) o.asel = 2'd1;
        o.bsel = (opc inside {OPIMM, LOAD, STORE, JALR, AUIPC, LUI});
        if (opc == BRANCH) begin
          o.pcw = 1'b1;
          o.pcs = bt ? 2'd1 : 2'd0;
          o.ret = 1'b1;
        end
      end
      PH_M: begin
        o.st  = 3'd3;
        o.req = 1'b1;
        o.we  = (opc == STORE);
        if (rdy && opc == STORE) begin
          o.pcw = 1'b1;
          o.ret = 1'b1;
        end
      end
      PH_W: begin
        o.st  = 3'd4;
        o.rw  = 1'b1;
        o.pcw = 1'b1;
        o.ret = 1'b1;
        o.wbs = (opc == LOAD) ? 2'd1 : ((opc == JAL || opc == JALR) ? 2'd2 : 2'd0);
        o.pcs = (opc == JAL) ? 2'd1 : ((opc == JALR) ? 2'd2 : 2'd0);
      end
      PH_T: begin
        o.st  = 3'd5;
        o.ill = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st   = state;
    o.req  = mif.mem_req;
    o.we   = mif.mem_we;
    o.irw  = ir_write;
    o.pcw  = pc_write;
    o.pcs  = pc_src;
    o.asel = alu_a_sel;
    o.bsel = alu_b_sel;
    o.wbs  = wb_sel;
    o.rw   = reg_write;
    o.ret  = instret;
    o.ill  = illegal;
    return o;
  endfunction

  // One clock: drive inputs at negedge, check just after, then take the edge.
  // mem_ready and branch_taken are randomized wherever they must be ignored.
  task automatic step(input int ph, input logic [6:0] opc, input logic rdy,
                      input logic bt, input string tag, output obs_t got);
    obs_t exp;
    logic r, b;
    @(negedge clk);
    opcode        = (ph == PH_F) ? 7'($urandom) : opc;
    r             = (ph == PH_F || ph == PH_M) ? rdy : 1'($urandom);
    b             = (ph == PH_E && opc == BRANCH) ? bt : 1'($urandom);
    mif.mem_ready = r;
    branch_taken  = b;
    #1;
    got = sample();
    exp = model(ph, opc, b, r);
    chk({tag, "/trace"}, {15'd0, got}, {15'd0, exp});
    @(posedge clk);
  endtask

  // Builds the phase list for one instruction and runs it cycle by cycle
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw,
                           input logic bt, input string tag,
                           output int cyc, output int nret,
                           output logic [1:0] rpcs, output logic [1:0] rwbs,
                           output logic any_rw, output logic any_we,
                           output logic [23:0] seq);
    int   ph_q[$];
    logic rdy_q[$];
    obs_t g;
    for (int i = 0; i < fw; i++) begin ph_q.push_back(PH_F); rdy_q.push_back(1'b0); end
    ph_q.push_back(PH_F); rdy_q.push_back(1'b1);
    ph_q.push_back(PH_D); rdy_q.push_back(1'b0);
    if (!is_legal(opc)) begin
      for (int i = 0; i < 10; i++) begin ph_q.push_back(PH_T); rdy_q.push_back(1'b0); end
    end else begin
      ph_q.push_back(PH_E); rdy_q.push_back(1'b0);
      if (opc == LOAD || opc == STORE) begin
        for (int i = 0; i < mw; i++) begin ph_q.push_back(PH_M); rdy_q.push_back(1'b0); end
        ph_q.push_back(PH_M); rdy_q.push_back(1'b1);
      end
      if (opc != BRANCH && opc != STORE) begin
        ph_q.push_back(PH_W); rdy_q.push_back(1'b0);
      end
    end
    cyc = 0; nret = 0; rpcs = 2'd3; rwbs = 2'd3; any_rw = 1'b0; any_we = 1'b0; seq = '0;
    foreach (ph_q[i]) begin
      step(ph_q[i], opc, rdy_q[i], bt, tag, g);
      cyc++;
      seq    = {seq[20:0], g.st};
      any_rw = any_rw | g.rw;
      any_we = any_we | g.we;
      if (g.ret) begin
        nret++;
        rpcs = g.pcs;
        rwbs = g.wbs;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst           = 1'b1;
      mif.mem_ready = 1'($urandom);
      branch_taken  = 1'($urandom);
      opcode        = 7'($urandom);
      #1;
      chk("reset/outputs",
          {18'd0, mif.mem_req, mif.mem_we, ir_write, pc_write, pc_src, alu_a_sel,
           alu_b_sel, wb_sel, reg_write, instret, illegal}, 32'd0);
      if (i > 0) chk("reset/state", {29'd0, state}, 32'd0);
      @(posedge clk);
    end
    #1 rst = 1'b0;
  endtask

  vec_t        tbl[12];
  logic [6:0]  legal_ops[9];
  int          cyc, nret, explat;
  logic [1:0]  rpcs, rwbs;
  logic        any_rw, any_we;
  logic [23:0] seq;
  obs_t        g;
  logic [6:0]  opc;
  int          fw, mw;
  logic        bt;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{OP,     0, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0, 24'o0124};
    tbl[1]  = '{LOAD,   2, 1'b0, 7, 2'd0, 2'd1, 1'b1, 1'b0, 24'o0123334};
    tbl[2]  = '{STORE,  0, 1'b0, 4, 2'd0, 2'd0, 1'b0, 1'b1, 24'o0123};
    tbl[3]  = '{BRANCH, 0, 1'b1, 3, 2'd1, 2'd0, 1'b0, 1'b0, 24'o012};
    tbl[4]  = '{BRANCH, 0, 1'b0, 3, 2'd0, 2'd0, 1'b0, 1'b0, 24'o012};
    tbl[5]  = '{JAL,    0, 1'b0, 4, 2'd1, 2'd2, 1'b1, 1'b0, 24'o0124};
    tbl[6]  = '{JALR,   0, 1'b0, 4, 2'd2, 2'd2, 1'b1, 1'b0, 24'o0124};
    tbl[7]  = '{LUI,    0, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0, 24'o0124};
    tbl[8]  = '{AUIPC,  0, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0, 24'o0124};
    tbl[9]  = '{OPIMM,  0, 1'b0, 4, 2'd0, 2'd0, 1'b1, 1'b0, 24'o0124};
    tbl[10] = '{LOAD,   0, 1'b0, 5, 2'd0, 2'd1, 1'b1, 1'b0, 24'o01234};
    tbl[11] = '{STORE,  3, 1'b0, 7, 2'd0, 2'd0, 1'b0, 1'b1, 24'o0123333};
    legal_ops = '{LOAD, OPIMM, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP};

    rst           = 1'b1;
    opcode        = 7'd0;
    branch_taken  = 1'b0;
    mif.mem_ready = 1'b0;

    // Reset held 3 cycles, then the first request appears immediately
    do_reset(3);
    @(negedge clk);
    mif.mem_ready = 1'b0;
    #1;
    chk("reset/first_req", {31'd0, mif.mem_req}, 32'd1);
    chk("reset/no_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk);

    // Directed table
    foreach (tbl[i]) begin
      run_instr(tbl[i].opc, 0, tbl[i].mw, tbl[i].bt, "tbl", cyc, nret, rpcs, rwbs,
                any_rw, any_we, seq);
      chk("tbl/cycles",  32'(cyc), 32'(tbl[i].cyc));
      chk("tbl/instret", 32'(nret), 32'd1);
      chk("tbl/pc_src",  {30'd0, rpcs}, {30'd0, tbl[i].pcs});
      chk("tbl/wb_sel",  {30'd0, rwbs}, {30'd0, tbl[i].wbs});
      chk("tbl/reg_wr",  {31'd0, any_rw}, {31'd0, tbl[i].rw});
      chk("tbl/mem_we",  {31'd0, any_we}, {31'd0, tbl[i].we});
      chk("tbl/states",  {8'd0, seq}, {8'd0, tbl[i].seq});
    end

    // Illegal opcode parks in TRAP; only reset leaves it
    run_instr(ILL, 1, 0, 1'b0, "illegal", cyc, nret, rpcs, rwbs, any_rw, any_we, seq);
    chk("illegal/cycles",  32'(cyc), 32'd13);
    chk("illegal/instret", 32'(nret), 32'd0);
    chk("illegal/reg_wr",  {31'd0, any_rw}, 32'd0);
    do_reset(2);

    // Store interrupted by reset while waiting in MEM
    step(PH_F, STORE, 1'b1, 1'b0, "swrst", g);
    step(PH_D, STORE, 1'b0, 1'b0, "swrst", g);
    step(PH_E, STORE, 1'b0, 1'b0, "swrst", g);
    step(PH_M, STORE, 1'b0, 1'b0, "swrst", g);
    @(negedge clk);
    rst           = 1'b1;
    mif.mem_ready = 1'b1;
    #1;
    chk("swrst/req_drop", {31'd0, mif.mem_req}, 32'd0);
    chk("swrst/strobes",
        {27'd0, mif.mem_we, ir_write, pc_write, reg_write, instret}, 32'd0);
    @(posedge clk);
    #1;
    chk("swrst/state", {29'd0, state}, 32'd0);
    rst = 1'b0;
    run_instr(OP, 0, 0, 1'b0, "swrst_after", cyc, nret, rpcs, rwbs, any_rw, any_we, seq);
    chk("swrst/restart_cycles", 32'(cyc), 32'd4);

    // Randomized instruction stream with random wait states
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        opc = 7'($urandom);
        while (is_legal(opc)) opc = 7'($urandom);
      end else begin
        opc = legal_ops[$urandom_range(0, 8)];
      end
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      bt = 1'($urandom);
      run_instr(opc, fw, mw, bt, "rand", cyc, nret, rpcs, rwbs, any_rw, any_we, seq);
      if (!is_legal(opc)) begin
        chk("rand/trap_instret", 32'(nret), 32'd0);
        do_reset(1);
      end else begin
        explat = (opc == BRANCH) ? 3 : ((opc == LOAD) ? 5 : 4);
        explat += fw + ((opc == LOAD || opc == STORE) ? mw : 0);
        chk("rand/latency", 32'(cyc), 32'(explat));
        chk("rand/instret", 32'(nret), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It also drives the datapath selects that route the immediate-generator output, PC and register operands into the ALU, PC mux and register-file write port. It sits between the instruction register (`opcode` = IR[6:0]) and the shared single-port memory. It owns the memory request handshake and all architectural write strobes.

## Interface
- No parameters. Opcode encodings are fixed RV32I: LOAD 0000011, OPIMM 0010011, JALR 1100111, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, OP 0110011.
- `clk`  in  1  single clock, rising edge. Reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  IR[6:0]. Held stable by the IR from DECODE until the next `ir_write`.
- `branch_taken`  in  1  ALU compare result. Sampled only in EXECUTE of a BRANCH.
- `mem_ready`  in  1  memory handshake completion. Ignored outside FETCH and MEM.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write enable, qualified by `mem_req`.
- `ir_write`  out  1  load IR from memory read data.
- `pc_write`  out  1  update PC.
- `pc_src`  out  2  next-PC source: 0 = PC+4, 1 = PC+imm, 2 = ALU result with bit 0 cleared.
- `alu_a_sel`  out  2  ALU A operand: 0 = rs1, 1 = PC, 2 = zero.
- `alu_b_sel`  out  1  ALU B operand: 0 = rs2, 1 = imm.
- `wb_sel`  out  2  register write data: 0 = ALU, 1 = memory data, 2 = PC+4.
- `reg_write`  out  1  register-file write strobe.
- `instret`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  sticky flag: unsupported opcode decoded.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.

## Operation
- The only registered state is `state` (3 bits). All other outputs are combinational from `state`, `opcode`, `branch_taken` and `mem_ready`. Any output not named for a state below is 0.
- **FETCH**
  - Drive `mem_req`=1, `mem_we`=0.
  - Hold while `mem_ready`=0.
  - When `mem_ready`=1: `ir_write`=1, next state DECODE.
- **DECODE**
  - Single cycle for register read and immediate generation.
  - Opcode not in the legal list: next state TRAP.
  - Legal opcode: next state EXECUTE.
- **EXECUTE operand selects**
  - OP: A=rs1, B=rs2.
  - OPIMM, LOAD, STORE, JALR: A=rs1, B=imm.
  - AUIPC: A=PC, B=imm.
  - LUI: A=zero, B=imm.
  - BRANCH: A=rs1, B=rs2.
  - JAL: selects are don't-care and are driven 0.
- **EXECUTE next-state**
  - BRANCH: `pc_write`=1, `pc_src`=`branch_taken`?1:0, `instret`=1, next state FETCH.
  - LOAD or STORE: next state MEM.
  - All other legal opcodes: next state WRITEBACK.
- **MEM**
  - Drive `mem_req`=1, `mem_we`=1 for STORE (0 for LOAD). The ALU result register supplies the address.
  - Hold while `mem_ready`=0.
  - On `mem_ready`=1, STORE: `pc_write`=1, `pc_src`=0, `instret`=1, next state FETCH.
  - On `mem_ready`=1, LOAD: next state WRITEBACK.
- **WRITEBACK**
  - Drive `reg_write`=1, `pc_write`=1, `instret`=1, next state FETCH.
  - `wb_sel`: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - `pc_src`: 1 for JAL, 2 for JALR (ALU = rs1+imm, the ALU result register holds the EXECUTE value), 0 otherwise.
- **TRAP**
  - All strobes are 0 and `illegal`=1.
  - Remains in TRAP until `rst`.
- `illegal` is asserted iff `state`==TRAP.

## Timing
- **Reset**
  - With `rst`=1 at a rising edge, `state` becomes FETCH.
  - While `rst` is high, all strobes are forced to 0: `mem_req`, `mem_we`, `ir_write`, `pc_write`, `reg_write`, `instret`.
  - `illegal` is 0 during reset. Selects read 0.
  - The first `mem_req` appears in the first cycle with `rst`=0.
- **Reset mid-operation**: an outstanding `mem_req` drops in the same cycle `rst` rises. No write strobe may fire in that cycle. The FSM restarts at FETCH.
- **Latency with zero wait** (`mem_ready` tied high), in cycles:
  - BRANCH: 3.
  - OP, OPIMM, LUI, AUIPC, JAL, JALR: 4.
  - STORE: 4.
  - LOAD: 5.
  - Each wait cycle in FETCH or MEM adds one cycle.
- **Handshake**
  - A transfer completes in the cycle where `mem_req` and `mem_ready` are both 1.
  - `mem_req` stays high and its `mem_we` value stays stable until completion.
  - `mem_ready` seen with `mem_req`=0 has no effect.
- Exactly one `instret` per retired instruction, coincident with that instruction's `pc_write`.

## Test plan
- **Reset**: hold `rst` 3 cycles, then release. Required:
  - During reset: `state`=0 and all strobes 0.
  - Cycle after release: `mem_req`=1.
  - `illegal`=0 throughout.
- **ADD** (opcode 0110011), `mem_ready`=1:
  - `state` sequence 0,1,2,4,0.
  - EXECUTE: `alu_b_sel`=0.
  - WRITEBACK: `reg_write`=1, `wb_sel`=0, `pc_src`=0, `instret`=1.
- **LW** with `mem_ready` low 2 cycles in MEM:
  - `state` sequence 0,1,2,3,3,3,4,0.
  - `mem_we`=0 throughout.
  - WRITEBACK: `wb_sel`=1.
  - 7 cycles total.
- **BEQ**, two runs:
  - `branch_taken`=1: EXECUTE gives `pc_write`=1, `pc_src`=1, then FETCH.
  - `branch_taken`=0: `pc_src`=0.
  - No `reg_write` in either run.
- **JAL then JALR**:
  - JAL WRITEBACK: `wb_sel`=2, `pc_src`=1.
  - JALR WRITEBACK: `wb_sel`=2, `pc_src`=2.
  - JALR EXECUTE: `alu_a_sel`=0, `alu_b_sel`=1.
- **Illegal opcode 1111111**:
  - DECODE goes to TRAP (`state`=5).
  - `illegal`=1 and no strobes for 10 cycles.
- **SW with reset asserted in MEM**:
  - `mem_req` drops the same cycle.
  - `state`=0 after the edge.
  - No `pc_write` or `instret` occurs.
